// File: rtl/des_pkg.sv
// Shared DES sequencing definitions.
// Holds the round-controller state type, the per-round C/D rotation tables
// for encrypt (rotate left) and decrypt (rotate right), and the index of the
// last round. The datapath and the bench import the same tables.
package des_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_HOLD  = 3'd4
    } des_state_e;

    localparam logic [3:0] ROUND_LAST = 4'd15;

    // Encrypt: left rotations before each subkey, total 28 over 16 rounds.
    localparam logic [1:0] ENC_SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Decrypt: right rotations. Round 0 uses K16, which equals the
    // freshly loaded C/D (left rotation totals 28), so no shift is needed.
    localparam logic [1:0] DEC_SHIFT [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

endpackage

// File: rtl/des_shift_sched.sv
// Key-schedule rotation lookup.
// Ports:
//   round_i      current round index 0..15
//   decrypt_i    latched mode (0 = encrypt, 1 = decrypt)
//   shift_amt_o  C/D rotation amount for this round
//   shift_dir_o  rotation direction (0 = left, 1 = right)
module des_shift_sched
    import des_pkg::*;
(
    input  logic [3:0] round_i,
    input  logic       decrypt_i,
    output logic [1:0] shift_amt_o,
    output logic       shift_dir_o
);

    assign shift_amt_o = decrypt_i ? DEC_SHIFT[round_i] : ENC_SHIFT[round_i];
    assign shift_dir_o = decrypt_i;

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer.
// Accepts one block over in_valid/in_ready, then steps the shared datapath
// through load, 16 rounds and final-permutation capture, and holds the
// result until out_ready. Owns no data bits.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   in_valid/in_ready host request handshake (in_ready only in IDLE)
//   in_decrypt        mode, sampled on the accept edge only
//   dp_load           load IP(data) into L/R and PC1(key) into C/D
//   dp_round_en       perform one round; dp_round is its index
//   dp_shift_amt/dir  C/D rotation for this round (0 outside ROUND)
//   dp_capture        capture final_perm(R16||L16)
//   out_valid/ready   result handshake
//   busy              any state other than IDLE
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// LOAD  | one cycle of dp_load, round counter cleared
// ROUND | one Feistel round per cycle, counter 0..15
// FINAL | one cycle of dp_capture
// HOLD  | out_valid high until out_ready
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int ROUNDS = 16  // only 16 is meaningful for the DES shift schedule
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_decrypt,
    output logic       dp_load,
    output logic       dp_round_en,
    output logic [3:0] dp_round,
    output logic [1:0] dp_shift_amt,
    output logic       dp_shift_dir,
    output logic       dp_capture,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam logic [3:0] CNT_LAST = 4'(ROUNDS - 1);

    des_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;

    logic [1:0] sched_amt;
    logic       sched_dir;
    logic       in_round;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mode_d  = in_decrypt;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = 4'd0;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FINAL;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_FINAL: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    des_shift_sched u_shift_sched (
        .round_i     (cnt_q),
        .decrypt_i   (mode_q),
        .shift_amt_o (sched_amt),
        .shift_dir_o (sched_dir)
    );

    // All outputs decode the registered state; nothing depends on inputs.
    assign in_round     = (state_q == ST_ROUND);
    assign in_ready     = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign dp_load      = (state_q == ST_LOAD);
    assign dp_round_en  = in_round;
    assign dp_round     = in_round ? cnt_q : 4'd0;
    assign dp_shift_amt = in_round ? sched_amt : 2'd0;
    assign dp_shift_dir = in_round & sched_dir;
    assign dp_capture   = (state_q == ST_FINAL);
    assign out_valid    = (state_q == ST_HOLD);

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl. The reference tracks "cycles since accept" and
// derives every expected output from the block timeline and the DES shift
// rules directly.
module tb_des_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_decrypt;
    logic       dp_load;
    logic       dp_round_en;
    logic [3:0] dp_round;
    logic [1:0] dp_shift_amt;
    logic       dp_shift_dir;
    logic       dp_capture;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    des_round_ctrl #(.ROUNDS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_decrypt   (in_decrypt),
        .dp_load      (dp_load),
        .dp_round_en  (dp_round_en),
        .dp_round     (dp_round),
        .dp_shift_amt (dp_shift_amt),
        .dp_shift_dir (dp_shift_dir),
        .dp_capture   (dp_capture),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: t = -1 idle, 1 load, 2..17 rounds, 18 capture, 19 hold.
    int   t        = -1;
    logic m_mode   = 1'b0;
    int   cyc      = 0;
    int   last_acc = -1;
    bit   b2b      = 1'b0;
    int   obs_rnds = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d t=%0d cyc=%0d", tag, obs, exp, t, cyc);
        end
    endtask

    function automatic int exp_amt(input int r, input logic dec);
        if (dec) return (r == 0) ? 0 : ((r == 1 || r == 8 || r == 15) ? 1 : 2);
        return (r == 0 || r == 1 || r == 8 || r == 15) ? 1 : 2;
    endfunction

    task automatic check_outputs();
        bit rnd;
        int r;
        rnd = (t >= 2 && t <= 17);
        r   = rnd ? t - 2 : 0;
        chk("in_ready",  int'(in_ready),    int'(t == -1));
        chk("busy",      int'(busy),        int'(t != -1));
        chk("dp_load",   int'(dp_load),     int'(t == 1));
        chk("round_en",  int'(dp_round_en), int'(rnd));
        chk("dp_round",  int'(dp_round),    r);
        chk("shift_amt", int'(dp_shift_amt), rnd ? exp_amt(r, m_mode) : 0);
        chk("shift_dir", int'(dp_shift_dir), rnd ? int'(m_mode) : 0);
        chk("capture",   int'(dp_capture),  int'(t == 18));
        chk("out_valid", int'(out_valid),   int'(t == 19));
        if (dp_round_en === 1'b1) obs_rnds++;
        if (t == 18) begin
            chk("rounds_per_blk", obs_rnds, 16);
            obs_rnds = 0;
        end
    endtask

    // One clock: drive inputs, check outputs, take the edge, advance model.
    task automatic cycle(input logic iv, input logic dec, input logic ordy, input logic rn);
        in_valid   = iv;
        in_decrypt = dec;
        out_ready  = ordy;
        rst_n      = rn;
        #1;
        check_outputs();
        @(posedge clk);
        cyc++;
        if (!rn) begin
            t        = -1;
            m_mode   = 1'b0;
            obs_rnds = 0;
        end else if (t == -1) begin
            if (iv) begin
                t        = 1;
                m_mode   = dec;
                obs_rnds = 0;
                if (b2b && last_acc >= 0) chk("accept_gap", cyc - last_acc, 20);
                last_acc = cyc;
            end
        end else if (t < 19) begin
            t++;
        end else if (ordy) begin
            t = -1;
        end
        #1;
    endtask

    task automatic run_to_idle(input logic ordy);
        int n = 0;
        while (t != -1 && n < 60) begin
            cycle(1'b0, 1'($urandom), ordy, 1'b1);
            n++;
        end
        if (t != -1) chk("idle_timeout", t, -1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_decrypt = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        t = -1;

        // reset held, then released idle
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // encrypt, then decrypt, out_ready high throughout
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        run_to_idle(1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        run_to_idle(1'b1);

        // output stall of 10 cycles
        cycle(1'b1, 1'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 30 && t != 19; i++) cycle(1'b0, 1'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("stall_hold", int'(out_valid), 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // busy rejection, mode toggling mid-block, random out_ready
        for (int i = 0; i < 80; i++)
            cycle(1'b1, 1'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
        run_to_idle(1'b1);

        // reset while dp_round == 7
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20 && t != 9; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("mid_round_idx", int'(dp_round), 7);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 22; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);

        // back-to-back blocks
        b2b = 1'b1;
        last_acc = -1;
        for (int i = 0; i < 60; i++) cycle(1'b1, 1'($urandom), 1'b1, 1'b1);
        b2b = 1'b0;
        run_to_idle(1'b1);

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 2) != 0), 1'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 60) != 0));
        run_to_idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/des_round_ctrl.md
# des_round_ctrl

Iterative DES round sequencer. Accepts one 64-bit block request at a time over a valid/ready handshake and sequences the shared single-round datapath through load, 16 Feistel rounds and final-permutation capture. For each round it drives the key-schedule rotation controls for encrypt or decrypt. It owns no data bits: it sits between the host interface and the datapath registers (L/R, C/D, output register fed by final_perm).

## Interface
Parameters:
- ROUNDS, 16, round count; only 16 is legal for DES, fixed by the shift schedule.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  host offers a block.
- in_ready  output  1  controller can accept; high only in IDLE.
- in_decrypt  input  1  mode; sampled only on the accept cycle (0 = encrypt, 1 = decrypt).
- dp_load  output  1  datapath loads IP(data) into L/R and PC1(key) into C/D.
- dp_round_en  output  1  datapath performs one round this cycle.
- dp_round  output  4  current round index, 0..15.
- dp_shift_amt  output  2  C/D rotation applied this round (0, 1 or 2).
- dp_shift_dir  output  1  0 = rotate left, 1 = rotate right.
- dp_capture  output  1  datapath captures final_perm(R16‖L16) into the output register.
- out_valid  output  1  result is available in the output register.
- out_ready  input  1  host takes the result.
- busy  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, ROUND, FINAL, HOLD.
- IDLE: in_ready=1. If in_valid=1, accept the block, latch mode, go to LOAD.
- LOAD: dp_load=1 for one cycle. Clear the round counter to 0. Go to ROUND.
- ROUND: dp_round_en=1 and dp_round=counter.
  - Counter below 15: increment and stay in ROUND.
  - Counter at 15: go to FINAL.
- FINAL: dp_capture=1 for one cycle. Go to HOLD.
- HOLD: out_valid=1. If out_ready=1, go to IDLE. Otherwise stay in HOLD and keep out_valid high.
- Shift schedule: dp_shift_amt is the rotation applied to C/D before subkey generation in that round.
  - Encrypt: dp_shift_dir=0. dp_shift_amt=1 at rounds 0, 1, 8 and 15; 2 at all other rounds. Total rotation is 28.
  - Decrypt: dp_shift_dir=1. dp_shift_amt=0 at round 0; 1 at rounds 1, 8 and 15; 2 at all other rounds.
- dp_shift_amt, dp_shift_dir and dp_round are 0 outside the ROUND state.
- The mode is held constant from accept until return to IDLE. in_decrypt changes mid-block are ignored.
- No overlap: a new block is accepted only from IDLE.
- Counter width is 4 bits. No wrap-around is possible, because the exit happens at 15.

## Timing
- All outputs are registered, or decoded from the registered state only. No input-to-output combinational path, except that in_ready is a function of state alone.
- Reset values: in_ready=1 and every other output 0. State is IDLE, counter is 0, mode is 0.
- Accept at cycle T, where in_valid and in_ready are both high at the rising edge:
  - dp_load at T+1.
  - dp_round_en at T+2..T+17, with dp_round 0..15.
  - dp_capture at T+18.
  - out_valid first high at T+19.
- Latency from accept to out_valid is 19 cycles.
- If out_ready is already high at T+19, the FSM is back in IDLE at T+20. Minimum block period is 20 cycles.
- out_valid stays high and stable for any out_ready stall length.
- An out_ready pulse outside HOLD is ignored.
- in_valid during busy is ignored, with in_ready=0.
- rst_n low at any edge forces the reset state on that edge and overrides every other event. There is no partial completion: an in-flight block is dropped and out_valid is not raised.

## Structure
- Shared package des_pkg holds:
  - the state enum type;
  - the 16-entry encrypt shift table;
  - the 16-entry decrypt shift table;
  - the ROUND_LAST=15 constant.
  These are also reused by the datapath and the bench.
- Sub-module des_shift_sched: combinational lookup (round, mode) -> (dp_shift_amt, dp_shift_dir). It is instantiated once; its outputs are gated to 0 outside ROUND.

## Test plan
- Reset release, then encrypt: in_valid=1 and in_decrypt=0 at cycle 5. Expect:
  - dp_load at 6;
  - dp_round_en at 7..22;
  - dp_shift_amt sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, with dp_shift_dir=0;
  - dp_capture at 23;
  - out_valid at 24.
- Decrypt: same stimulus with in_decrypt=1. Expect dp_shift_amt sequence 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, with dp_shift_dir=1 throughout ROUND.
- Output stall: out_ready=0 for 10 cycles after out_valid. Expect out_valid held high for 11 cycles and in_ready=0. On out_ready=1, expect IDLE with in_ready=1 on the next cycle.
- Busy rejection and mode latch: hold in_valid=1 throughout and toggle in_decrypt during ROUND. Expect in_ready=0, no second dp_load, and the shift direction unchanged. Expect the second accept exactly at the first out_ready cycle+1.
- Reset mid-round: rst_n=0 for one edge at dp_round=7. Expect all outputs at reset values on the next cycle, with in_ready=1, and no dp_capture or out_valid.
- Back-to-back: out_ready tied to 1 and in_valid tied to 1 for three blocks. Expect accepts exactly 20 cycles apart and 16 dp_round_en pulses per block.
